// File: rtl/snoop_bus_controller.sv
// Snooping-bus controller: latches per-core misses, arbitrates round-robin,
// snoops the other caches and fills the requester from memory or an M owner.
module snoop_bus_controller #(
    parameter int NUM_CORES     = 2,
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            core_bus_req_valid,
    input  logic [2*NUM_CORES-1:0]          core_bus_req_type,
    input  logic [ADDRESS_WIDTH*NUM_CORES-1:0] core_bus_req_addr,
    output logic [NUM_CORES-1:0]            bus_snoop_valid,
    output logic [1:0]                      bus_snoop_type,
    output logic [ADDRESS_WIDTH-1:0]        bus_snoop_addr,
    input  logic [NUM_CORES-1:0]            snoop_resp_valid,
    input  logic [NUM_CORES-1:0]            snoop_resp_hit,
    input  logic [2*NUM_CORES-1:0]          snoop_resp_state,
    input  logic [DATA_WIDTH*NUM_CORES-1:0] snoop_resp_data,
    output logic [DATA_WIDTH-1:0]           bus_data_in,
    output logic [NUM_CORES-1:0]            bus_data_in_valid,
    output logic                            mem_req_valid,
    output logic                            mem_req_write,
    output logic [ADDRESS_WIDTH-1:0]        mem_req_addr,
    output logic [DATA_WIDTH-1:0]           mem_req_wdata,
    input  logic                            mem_req_ready,
    input  logic                            mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]           mem_resp_data,
    output logic                            busy,
    output logic [$clog2(NUM_CORES)-1:0]    grant_id
);

    localparam int IDW = $clog2(NUM_CORES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNOOP,
        S_COLLECT,
        S_WB,
        S_MEM_RD,
        S_MEM_WAIT,
        S_FILL
    } state_e;

    state_e                                 state_q, state_d;
    logic [NUM_CORES-1:0]                   pend_q, pend_d;
    logic [NUM_CORES-1:0][1:0]              ptype_q, ptype_d;
    logic [NUM_CORES-1:0][ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
    logic [IDW-1:0]                         ptr_q, ptr_d;
    logic [IDW-1:0]                         grant_q, grant_d;
    logic [1:0]                             rtype_q, rtype_d;
    logic [ADDRESS_WIDTH-1:0]               raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0]                  data_q, data_d;

    logic                                   arb_any;
    logic [IDW-1:0]                         arb_idx;
    logic                                   own_found;
    logic [DATA_WIDTH-1:0]                  own_data;

    // Pending latches: the clear for the filled core happens before the set,
    // so a fresh pulse in the FILL cycle re-arms the latch.
    always_comb begin
        pend_d  = pend_q;
        ptype_d = ptype_q;
        paddr_d = paddr_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (state_q == S_FILL && grant_q == IDW'(i)) begin
                pend_d[i] = 1'b0;
            end
            if (core_bus_req_valid[i] && !pend_d[i]) begin
                pend_d[i]  = 1'b1;
                ptype_d[i] = core_bus_req_type[2*i +: 2];
                paddr_d[i] = core_bus_req_addr[ADDRESS_WIDTH*i +: ADDRESS_WIDTH];
            end
        end
    end

    // Round-robin pick: first pending core at or after the pointer.
    always_comb begin
        int j;
        j       = 0;
        arb_any = 1'b0;
        arb_idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_CORES) begin
                j = j - NUM_CORES;
            end
            if (!arb_any && pend_q[j[IDW-1:0]]) begin
                arb_any = 1'b1;
                arb_idx = j[IDW-1:0];
            end
        end
    end

    // Lowest-index Modified owner among the snoop responses.
    always_comb begin
        own_found = 1'b0;
        own_data  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (snoop_resp_valid[i] && snoop_resp_hit[i] &&
                snoop_resp_state[2*i +: 2] == 2'b11) begin
                own_found = 1'b1;
                own_data  = snoop_resp_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Transaction FSM: next state and all bus/memory outputs.
    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        grant_d           = grant_q;
        rtype_d           = rtype_q;
        raddr_d           = raddr_q;
        data_d            = data_q;
        bus_snoop_valid   = '0;
        bus_snoop_type    = '0;
        bus_snoop_addr    = '0;
        bus_data_in       = '0;
        bus_data_in_valid = '0;
        mem_req_valid     = 1'b0;
        mem_req_write     = 1'b0;
        mem_req_addr      = '0;
        mem_req_wdata     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    rtype_d = ptype_q[arb_idx];
                    raddr_d = paddr_q[arb_idx];
                    ptr_d   = (arb_idx == IDW'(NUM_CORES - 1)) ?
                              '0 : arb_idx + 1'b1;
                    state_d = S_SNOOP;
                end
            end
            S_SNOOP: begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    bus_snoop_valid[i] = (grant_q != IDW'(i));
                end
                bus_snoop_type = rtype_q;
                bus_snoop_addr = raddr_q;
                state_d        = S_COLLECT;
            end
            S_COLLECT: begin
                if (own_found) begin
                    data_d  = own_data;
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_WB: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = raddr_q;
                mem_req_wdata = data_q;
                if (mem_req_ready) begin
                    state_d = S_FILL;
                end
            end
            S_MEM_RD: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = raddr_q;
                if (mem_req_ready) begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    data_d  = mem_resp_data;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                bus_data_in_valid[grant_q] = 1'b1;
                bus_data_in                = data_q;
                state_d                    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            ptype_q <= '0;
            paddr_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            rtype_q <= '0;
            raddr_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            paddr_q <= paddr_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            rtype_q <= rtype_d;
            raddr_q <= raddr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Scoreboard bench for snoop_bus_controller: directed transactions push
// expected snoops, memory requests and fills; a monitor pops and compares.
module tb_snoop_bus_controller;

    logic        clk;
    logic        reset;
    logic [1:0]  core_bus_req_valid;
    logic [3:0]  core_bus_req_type;
    logic [11:0] core_bus_req_addr;
    logic [1:0]  bus_snoop_valid;
    logic [1:0]  bus_snoop_type;
    logic [5:0]  bus_snoop_addr;
    logic [1:0]  snoop_resp_valid;
    logic [1:0]  snoop_resp_hit;
    logic [3:0]  snoop_resp_state;
    logic [63:0] snoop_resp_data;
    logic [31:0] bus_data_in;
    logic [1:0]  bus_data_in_valid;
    logic        mem_req_valid;
    logic        mem_req_write;
    logic [5:0]  mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        busy;
    logic [0:0]  grant_id;

    snoop_bus_controller #(
        .NUM_CORES(2), .ADDRESS_WIDTH(6), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset),
        .core_bus_req_valid(core_bus_req_valid),
        .core_bus_req_type(core_bus_req_type),
        .core_bus_req_addr(core_bus_req_addr),
        .bus_snoop_valid(bus_snoop_valid),
        .bus_snoop_type(bus_snoop_type),
        .bus_snoop_addr(bus_snoop_addr),
        .snoop_resp_valid(snoop_resp_valid),
        .snoop_resp_hit(snoop_resp_hit),
        .snoop_resp_state(snoop_resp_state),
        .snoop_resp_data(snoop_resp_data),
        .bus_data_in(bus_data_in),
        .bus_data_in_valid(bus_data_in_valid),
        .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .busy(busy),
        .grant_id(grant_id)
    );

    typedef struct {
        logic [1:0] mask;
        logic [1:0] typ;
        logic [5:0] addr;
    } snp_t;
    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } mem_t;
    typedef struct {
        int          core;
        logic [31:0] data;
        int          cyc;
    } fill_t;

    snp_t  snp_q[$];
    mem_t  mem_q[$];
    fill_t fill_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [1:0]  cfg_hit;
    logic [3:0]  cfg_state;
    logic [63:0] cfg_data;
    logic [31:0] mem_rdata;
    logic        mem_hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every DUT bus event against the scoreboard queues.
    initial begin
        snp_t  s;
        mem_t  m;
        fill_t f;
        forever begin
            @(negedge clk);
            if (bus_snoop_valid != 2'b00) begin
                if (snp_q.size() == 0) begin
                    flag("snoop unexpected");
                end else begin
                    s = snp_q.pop_front();
                    chk("snoop_mask", bus_snoop_valid, s.mask);
                    chk("snoop_type", bus_snoop_type, s.typ);
                    chk("snoop_addr", bus_snoop_addr, s.addr);
                end
            end
            if (mem_req_valid) begin
                if (mem_q.size() == 0) begin
                    flag("mem request unexpected");
                end else begin
                    m = mem_q[0];
                    chk(mem_req_ready ? "mem_write" : "stall_write",
                        mem_req_write, m.wr);
                    chk(mem_req_ready ? "mem_addr" : "stall_addr",
                        mem_req_addr, m.addr);
                    chk(mem_req_ready ? "mem_wdata" : "stall_wdata",
                        mem_req_wdata, m.wdata);
                    if (mem_req_ready) void'(mem_q.pop_front());
                end
            end
            if (bus_data_in_valid != 2'b00) begin
                if (fill_q.size() == 0) begin
                    flag("fill unexpected");
                end else begin
                    f = fill_q.pop_front();
                    chk("fill_mask", bus_data_in_valid, 2'b01 << f.core);
                    chk("fill_data", bus_data_in, f.data);
                    chk("fill_grant", grant_id, f.core);
                    chk("fill_cycle", cyc, f.cyc);
                end
            end
        end
    end

    // Snoop responder: answers one cycle after each snoop strobe.
    initial begin
        logic [1:0] sm;
        forever begin
            @(negedge clk);
            if (bus_snoop_valid != 2'b00) begin
                sm = bus_snoop_valid;
                @(posedge clk);
                #1;
                snoop_resp_valid = sm;
                snoop_resp_hit   = cfg_hit & sm;
                snoop_resp_state = cfg_state;
                snoop_resp_data  = cfg_data;
                @(posedge clk);
                #1;
                snoop_resp_valid = 2'b00;
                snoop_resp_hit   = 2'b00;
                snoop_resp_state = 4'b0000;
                snoop_resp_data  = '0;
            end
        end
    end

    // Memory responder: read data the cycle after the read is accepted.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready && !mem_req_write && !mem_hold) begin
                @(posedge clk);
                #1;
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_rdata;
                @(posedge clk);
                #1;
                mem_resp_valid = 1'b0;
                mem_resp_data  = '0;
            end
        end
    end

    task automatic pulse(input logic [1:0] v, input logic [3:0] t,
                         input logic [11:0] a, output int c);
        @(posedge clk);
        #1;
        core_bus_req_valid = v;
        core_bus_req_type  = t;
        core_bus_req_addr  = a;
        c = cyc;
        @(posedge clk);
        #1;
        core_bus_req_valid = 2'b00;
    endtask

    task automatic expect_txn(input int core, input logic [1:0] t,
                              input logic [5:0] a, input logic wb,
                              input logic [31:0] d, input int fcyc,
                              input bit with_fill);
        snp_t  s;
        mem_t  m;
        fill_t f;
        s.mask  = 2'b11 & ~(2'b01 << core);
        s.typ   = t;
        s.addr  = a;
        m.wr    = wb;
        m.addr  = a;
        m.wdata = wb ? d : 32'h0;
        f.core  = core;
        f.data  = d;
        f.cyc   = fcyc;
        snp_q.push_back(s);
        mem_q.push_back(m);
        if (with_fill) fill_q.push_back(f);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((fill_q.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_timeout"}, (fill_q.size() != 0 || busy), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_snoop"}, bus_snoop_valid, 0);
        chk({name, "_fillv"}, bus_data_in_valid, 0);
        chk({name, "_fill_data"}, bus_data_in, 0);
        chk({name, "_memv"}, mem_req_valid, 0);
        chk({name, "_mem_addr"}, mem_req_addr, 0);
        chk({name, "_grant"}, grant_id, 0);
    endtask

    initial begin
        int c;
        logic [31:0] d;
        reset              = 1'b0;
        core_bus_req_valid = 2'b00;
        core_bus_req_type  = 4'b0000;
        core_bus_req_addr  = 12'h000;
        snoop_resp_valid   = 2'b00;
        snoop_resp_hit     = 2'b00;
        snoop_resp_state   = 4'b0000;
        snoop_resp_data    = '0;
        mem_req_ready      = 1'b1;
        mem_resp_valid     = 1'b0;
        mem_resp_data      = '0;
        cfg_hit            = 2'b00;
        cfg_state          = 4'b0000;
        cfg_data           = '0;
        mem_rdata          = '0;
        mem_hold           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        reset = 1'b1;

        // Read miss, no sharers.
        mem_rdata = 32'hDEADBEEF;
        pulse(2'b01, 4'b0001, {6'h00, 6'h14}, c);
        expect_txn(0, 2'b01, 6'h14, 1'b0, 32'hDEADBEEF, c + 6, 1);
        wait_done("read_miss");

        // Modified owner in core1 supplies the line with write-back.
        cfg_hit   = 2'b10;
        cfg_state = 4'b1100;
        cfg_data  = {32'hCAFE0001, 32'h0};
        pulse(2'b01, 4'b0001, {6'h00, 6'h14}, c);
        expect_txn(0, 2'b01, 6'h14, 1'b1, 32'hCAFE0001, c + 5, 1);
        wait_done("owner_wb");

        // BusRdX from core1; core0 holds E, memory still sources the data.
        cfg_hit   = 2'b01;
        cfg_state = 4'b0010;
        cfg_data  = {32'h0, 32'hBAD0BAD0};
        mem_rdata = 32'h12345678;
        pulse(2'b10, 4'b1000, {6'h08, 6'h00}, c);
        expect_txn(1, 2'b10, 6'h08, 1'b0, 32'h12345678, c + 6, 1);
        wait_done("busrdx");

        // Simultaneous requests, twice; core0 wins both times.
        cfg_hit   = 2'b00;
        cfg_state = 4'b0000;
        cfg_data  = '0;
        mem_rdata = 32'h11112222;
        pulse(2'b11, 4'b0101, {6'h24, 6'h20}, c);
        expect_txn(0, 2'b01, 6'h20, 1'b0, 32'h11112222, c + 6, 1);
        expect_txn(1, 2'b01, 6'h24, 1'b0, 32'h11112222, c + 12, 1);
        wait_done("pair1");
        pulse(2'b11, 4'b0101, {6'h34, 6'h30}, c);
        expect_txn(0, 2'b01, 6'h30, 1'b0, 32'h11112222, c + 6, 1);
        expect_txn(1, 2'b01, 6'h34, 1'b0, 32'h11112222, c + 12, 1);
        wait_done("pair2");

        // Memory stall of 5 cycles on the read request.
        mem_rdata     = 32'hA5A55A5A;
        mem_req_ready = 1'b0;
        pulse(2'b01, 4'b0001, {6'h00, 6'h3C}, c);
        expect_txn(0, 2'b01, 6'h3C, 1'b0, 32'hA5A55A5A, c + 11, 1);
        repeat (3) @(posedge clk);
        #1;
        repeat (5) @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        wait_done("stall");

        // Reset while waiting for memory data: no fill afterwards.
        mem_hold  = 1'b1;
        pulse(2'b10, 4'b0100, {6'h2A, 6'h00}, c);
        expect_txn(1, 2'b01, 6'h2A, 1'b0, 32'h0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_quiet("abort");
        chk("abort_snp_q", snp_q.size(), 0);
        chk("abort_mem_q", mem_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b1;
        mem_hold = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_abort_busy", busy, 0);

        // Fresh request after reset completes normally.
        d         = 32'h600DF00D;
        mem_rdata = d;
        pulse(2'b10, 4'b1000, {6'h2A, 6'h00}, c);
        expect_txn(1, 2'b10, 6'h2A, 1'b0, d, c + 6, 1);
        wait_done("after_reset");

        chk("end_snp_q", snp_q.size(), 0);
        chk("end_mem_q", mem_q.size(), 0);
        chk("end_fill_q", fill_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snoop_bus_controller.md
# snoop_bus_controller

Shared snooping-bus controller sitting directly downstream of the per-core `Cache` instances and upstream of main memory. It latches each cache's one-cycle miss pulse and arbitrates among the caches round-robin. For the winner it broadcasts a snoop to every other cache, collects their snoop responses, sources the line from memory or from a Modified owner (with write-back), and returns fill data to the requester.

## Interface
- `NUM_CORES`, 2, number of attached caches (2..4)
- `ADDRESS_WIDTH`, 6, byte address width
- `DATA_WIDTH`, 32, line/word data width

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `core_bus_req_valid`  in  NUM_CORES  one-cycle miss pulse per core
- `core_bus_req_type`  in  2*NUM_CORES  per core: 01 BusRd, 10 BusRdX
- `core_bus_req_addr`  in  ADDRESS_WIDTH*NUM_CORES  per-core miss address
- `bus_snoop_valid`  out  NUM_CORES  per-core snoop strobe (never to requester)
- `bus_snoop_type`  out  2  shared snoop type
- `bus_snoop_addr`  out  ADDRESS_WIDTH  shared snoop address
- `snoop_resp_valid`  in  NUM_CORES  per-core snoop response valid
- `snoop_resp_hit`  in  NUM_CORES  per-core hit flag
- `snoop_resp_state`  in  2*NUM_CORES  per-core state: 00 I, 01 S, 10 E, 11 M
- `snoop_resp_data`  in  DATA_WIDTH*NUM_CORES  per-core line data
- `bus_data_in`  out  DATA_WIDTH  shared fill data
- `bus_data_in_valid`  out  NUM_CORES  one-hot fill strobe to the requester
- `mem_req_valid`  out  1  memory request, held until accepted
- `mem_req_write`  out  1  1 = write-back, 0 = read
- `mem_req_addr`  out  ADDRESS_WIDTH  memory address
- `mem_req_wdata`  out  DATA_WIDTH  write-back data
- `mem_req_ready`  in  1  memory accepts on `valid && ready`
- `mem_resp_valid`  in  1  read data valid, single outstanding read
- `mem_resp_data`  in  DATA_WIDTH  read data
- `busy`  out  1  state != IDLE
- `grant_id`  out  $clog2(NUM_CORES)  current or last granted core

## Operation
- Per-core pending latch:
  - `core_bus_req_valid[i]` sets `pending[i]` and captures its type and address.
  - A pulse while `pending[i]` is set is ignored.
  - `pending[i]` clears in the FILL cycle for core i. A set in the same cycle as the clear wins.
- Round-robin arbiter:
  - Pointer resets to 0.
  - In IDLE with any pending core, it grants the first pending core at or after the pointer.
  - After a grant, pointer = (grant+1) mod NUM_CORES.
- FSM states: IDLE, SNOOP, COLLECT, WB, MEM_RD, MEM_WAIT, FILL.
  - IDLE → SNOOP when any core is pending. Latch grant, type and address.
  - SNOOP (1 cycle): `bus_snoop_valid` = all ones except the grant bit. `bus_snoop_type` and `bus_snoop_addr` come from the granted request. → COLLECT.
  - COLLECT (1 cycle): sample the responses. A core counts as an owner if `valid && hit && state==11`; the lowest-index owner is used. With an owner, capture its data and go → WB; otherwise → MEM_RD.
  - WB: `mem_req_valid=1`, `mem_req_write=1`, addr = granted address, wdata = owner data. On ready → FILL, with fill data = owner data.
  - MEM_RD: `mem_req_valid=1`, `mem_req_write=0`. On ready → MEM_WAIT.
  - MEM_WAIT: on `mem_resp_valid`, capture the data → FILL.
  - FILL (1 cycle): `bus_data_in_valid[grant]=1` with `bus_data_in` = captured data. Clear `pending[grant]` and go → IDLE.
- Snoop responses from S or E holders do not change the data source; memory is used.
- `mem_req_*` signals are stable while valid and not ready.

## Timing
- Reset values: all outputs 0, FSM IDLE, pending cleared, pointer 0.
- Reset assertion at any point aborts the transaction. No fill is issued for the aborted request; it must be re-requested.
- Best-case latency, with request pulse at cycle C and memory ready and responding in the minimum time:
  - pending set C+1, IDLE grant C+1, snoop C+2, collect C+3.
  - Read path: mem read accepted C+4, resp C+5, fill C+6.
  - Write-back path: mem write accepted C+4, fill C+5.
- One transaction at a time. A second pending core is granted at the earliest in the cycle after FILL.
- Snoop responses are sampled exactly one cycle after the snoop strobe. Responses arriving at any other time are ignored.

## Test plan
- Read miss, no sharers: core0 BusRd addr 0x14, mem returns 0xDEADBEEF → `bus_snoop_valid`=10, mem read of 0x14, `bus_data_in_valid`=01 with 0xDEADBEEF at C+6.
- Modified owner: core1 holds 0x14 in M with 0xCAFE0001; core0 BusRd 0x14 → mem write 0x14/0xCAFE0001, fill core0 with 0xCAFE0001, no mem read.
- Simultaneous requests: core0 and core1 pulse in the same cycle → core0 served first, core1 next. Repeat the pair: core0 is then served before core1 again (pointer back at 0 after the core1 grant).
- BusRdX: core1 BusRdX 0x08 → `bus_snoop_type`=10, `bus_snoop_valid`=01, fill to core1 from memory.
- Memory stall: `mem_req_ready` held low 5 cycles → request fields held stable, fill delayed exactly 5 cycles.
- Reset mid-transaction: assert reset in MEM_WAIT → all outputs 0 and no fill after release. A new request after release completes normally.
